// File: rtl/player_input_ctrl.sv
// N-player input front end: sync, debounce, direction clean, frame-latched moves
// and a per-player arm/fire/cooldown shot FSM.
// Ports:
//   clk_i, reset_ni (async active-low), frame_start_i (vblank pulse)
//   move_i  [4*N] raw {right,left,down,up} per player -> move_o [4*N] latched
//   shoot_i [N]   raw shoot buttons  -> shoot_o [N] one-cycle shot pulse
//   cooldown_o [N] high while a player is in cooldown
module player_input_ctrl #(
    parameter int NUM_PLAYERS     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int COOLDOWN_FRAMES = 8,
    parameter int AUTOFIRE_EN     = 0
) (
    input  logic                     clk_i,
    input  logic                     reset_ni,
    input  logic                     frame_start_i,
    input  logic [4*NUM_PLAYERS-1:0] move_i,
    input  logic [NUM_PLAYERS-1:0]   shoot_i,
    output logic [4*NUM_PLAYERS-1:0] move_o,
    output logic [NUM_PLAYERS-1:0]   shoot_o,
    output logic [NUM_PLAYERS-1:0]   cooldown_o
);

    localparam int NB = 5 * NUM_PLAYERS;
    localparam int MB = 4 * NUM_PLAYERS;
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int FW = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
    localparam bit AF = (AUTOFIRE_EN != 0);
    localparam bit CD = (COOLDOWN_FRAMES > 0);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        FIRE,
        COOLDOWN
    } state_t;

    logic [NB-1:0]          raw;
    logic [NB-1:0]          sync1;
    logic [NB-1:0]          sync2;
    logic [NB-1:0]          stable;
    logic [DW-1:0]          db_cnt [NB];
    logic [MB-1:0]          clean;
    logic [NUM_PLAYERS-1:0] shoot_db;
    logic [NUM_PLAYERS-1:0] shoot_q;
    logic [NUM_PLAYERS-1:0] press;
    state_t                 state    [NUM_PLAYERS];
    state_t                 state_nx [NUM_PLAYERS];
    logic [FW-1:0]          fcnt     [NUM_PLAYERS];
    logic [FW-1:0]          fcnt_nx  [NUM_PLAYERS];

    assign raw = {shoot_i, move_i};

    // Two-flop synchroniser followed by a per-bit stability counter.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            sync1  <= '0;
            sync2  <= '0;
            stable <= '0;
            for (int i = 0; i < NB; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int i = 0; i < NB; i++) begin
                if (sync2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    stable[i] <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DW'(1);
                end
            end
        end
    end

    // Opposing directions held together cancel each other.
    always_comb begin
        clean = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            clean[4*p+0] = stable[4*p+0] & ~stable[4*p+1];
            clean[4*p+1] = stable[4*p+1] & ~stable[4*p+0];
            clean[4*p+2] = stable[4*p+2] & ~stable[4*p+3];
            clean[4*p+3] = stable[4*p+3] & ~stable[4*p+2];
        end
    end

    assign shoot_db = stable[MB +: NUM_PLAYERS];
    assign press    = shoot_db & ~shoot_q;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            move_o  <= '0;
            shoot_q <= '0;
        end else begin
            shoot_q <= shoot_db;
            if (frame_start_i) begin
                move_o <= clean;
            end
        end
    end

    // Shot FSM: state register.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                state[p] <= IDLE;
                fcnt[p]  <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                state[p] <= state_nx[p];
                fcnt[p]  <= fcnt_nx[p];
            end
        end
    end

    // Shot FSM: next state. A press while armed or cooling is simply dropped.
    always_comb begin
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            state_nx[p] = state[p];
            fcnt_nx[p]  = fcnt[p];
            unique case (state[p])
                IDLE: begin
                    if (press[p] || (AF && shoot_db[p])) begin
                        state_nx[p] = ARMED;
                    end
                end
                ARMED: begin
                    if (frame_start_i) begin
                        state_nx[p] = FIRE;
                    end
                end
                FIRE: begin
                    if (CD) begin
                        state_nx[p] = COOLDOWN;
                        fcnt_nx[p]  = FW'(COOLDOWN_FRAMES);
                    end else begin
                        state_nx[p] = IDLE;
                    end
                end
                COOLDOWN: begin
                    if (frame_start_i) begin
                        // Count of 0 or 1 both end here, so it never wraps.
                        if (fcnt[p] <= FW'(1)) begin
                            state_nx[p] = IDLE;
                            fcnt_nx[p]  = '0;
                        end else begin
                            fcnt_nx[p] = fcnt[p] - FW'(1);
                        end
                    end
                end
                default: begin
                    state_nx[p] = IDLE;
                end
            endcase
        end
    end

    // Shot FSM: outputs.
    always_comb begin
        shoot_o    = '0;
        cooldown_o = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            shoot_o[p]    = (state[p] == FIRE);
            cooldown_o[p] = (state[p] == COOLDOWN);
        end
    end

endmodule

// File: tb/tb_player_input_ctrl.sv
// Directed bench for player_input_ctrl: a manual-fire and an autofire instance,
// shots checked against a queue of expected {cycle, value} entries.
module tb_player_input_ctrl;

    logic       clk_i;
    logic       reset_ni;
    logic       frame_start_i;
    logic [7:0] move_i;
    logic [1:0] shoot_i;
    logic [1:0] shoot_af_i;
    logic [7:0] move_o;
    logic [1:0] shoot_o;
    logic [1:0] cooldown_o;
    logic [7:0] move_af_o;
    logic [1:0] shoot_af_o;
    logic [1:0] cooldown_af_o;

    typedef struct {
        int         cyc;
        logic [1:0] val;
    } shot_t;

    shot_t exp_q[$];
    shot_t exp_af_q[$];
    shot_t e_m;
    shot_t e_af;

    int cyc     = 0;
    int n_assert = 0;
    int n_fail  = 0;
    int n_shots = 0;
    int s0;

    player_input_ctrl #(
        .NUM_PLAYERS(2), .DEBOUNCE_CYCLES(4),
        .COOLDOWN_FRAMES(2), .AUTOFIRE_EN(0)
    ) dut (
        .clk_i(clk_i), .reset_ni(reset_ni),
        .frame_start_i(frame_start_i),
        .move_i(move_i), .shoot_i(shoot_i),
        .move_o(move_o), .shoot_o(shoot_o),
        .cooldown_o(cooldown_o)
    );

    player_input_ctrl #(
        .NUM_PLAYERS(2), .DEBOUNCE_CYCLES(4),
        .COOLDOWN_FRAMES(2), .AUTOFIRE_EN(1)
    ) dut_af (
        .clk_i(clk_i), .reset_ni(reset_ni),
        .frame_start_i(frame_start_i),
        .move_i(move_i), .shoot_i(shoot_af_i),
        .move_o(move_af_o), .shoot_o(shoot_af_o),
        .cooldown_o(cooldown_af_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    always @(posedge clk_i) cyc <= cyc + 1;

    // Frame pulse during every cycle whose number is a multiple of 64.
    initial begin
        frame_start_i = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            frame_start_i = (cyc % 64 == 0) && (cyc != 0);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic goto(input int t);
        while (cyc < t) begin
            @(posedge clk_i);
            #2;
        end
    endtask

    // Scoreboard side: every shot pulse pops one expected entry.
    always @(negedge clk_i) begin
        if (shoot_o !== 2'b00) begin
            n_shots++;
            if (exp_q.size() == 0) begin
                chk("unexpected_shot", 32'(shoot_o), 32'd0);
            end else begin
                e_m = exp_q.pop_front();
                chk("shot_cycle", 32'(cyc), 32'(e_m.cyc));
                chk("shot_val", 32'(shoot_o), 32'(e_m.val));
            end
        end
        if (shoot_af_o !== 2'b00) begin
            if (exp_af_q.size() == 0) begin
                chk("unexpected_af_shot", 32'(shoot_af_o), 32'd0);
            end else begin
                e_af = exp_af_q.pop_front();
                chk("af_shot_cycle", 32'(cyc), 32'(e_af.cyc));
                chk("af_shot_val", 32'(shoot_af_o), 32'(e_af.val));
            end
        end
    end

    initial begin
        reset_ni   = 1'b0;
        move_i     = '0;
        shoot_i    = '0;
        shoot_af_i = '0;

        // Reset state.
        goto(3);
        chk("rst_move", 32'(move_o), 32'h0);
        chk("rst_shoot", 32'(shoot_o), 32'h0);
        chk("rst_cool", 32'(cooldown_o), 32'h0);
        chk("rst_af_move", 32'(move_af_o), 32'h0);
        goto(5);
        reset_ni = 1'b1;

        // Moves latch only at a frame; then reset mid-frame with a shot armed.
        goto(10);
        move_i = 8'h11;
        goto(40);
        chk("move_prelatch", 32'(move_o), 32'h00);
        goto(66);
        chk("move_latched", 32'(move_o), 32'h11);
        goto(70);
        shoot_i = 2'b01;
        goto(96);
        move_i   = '0;
        shoot_i  = '0;
        reset_ni = 1'b0;
        #1;
        chk("rst_async_move", 32'(move_o), 32'h00);
        chk("rst_async_shoot", 32'(shoot_o), 32'h0);
        chk("rst_async_cool", 32'(cooldown_o), 32'h0);
        goto(100);
        reset_ni = 1'b1;
        goto(129);
        chk("post_rst_shoot", 32'(shoot_o), 32'h0);
        chk("post_rst_move", 32'(move_o), 32'h00);

        // Glitch of 3 clocks is rejected.
        goto(140);
        s0 = n_shots;
        shoot_i = 2'b01;
        goto(143);
        shoot_i = 2'b00;
        goto(396);
        chk("glitch_no_shot", 32'(n_shots), 32'(s0));
        chk("glitch_no_cool", 32'(cooldown_o), 32'h0);

        // Single fire, two-frame cooldown, press during cooldown dropped.
        goto(449);
        shoot_i = 2'b01;
        exp_q.push_back('{cyc: 513, val: 2'b01});
        goto(469);
        shoot_i = 2'b00;
        goto(513);
        chk("fire_pulse", 32'(shoot_o), 32'h1);
        chk("fire_no_cool", 32'(cooldown_o), 32'h0);
        goto(514);
        chk("cool_start", 32'(cooldown_o), 32'h1);
        goto(540);
        shoot_i = 2'b01;
        goto(560);
        shoot_i = 2'b00;
        goto(640);
        chk("cool_last", 32'(cooldown_o), 32'h1);
        goto(641);
        chk("cool_end", 32'(cooldown_o), 32'h0);

        // Direction cleaning: 0111 -> 0100, 1110 -> 0010.
        goto(818);
        move_i = 8'hE7;
        goto(828);
        move_i = 8'h00;
        goto(832);
        chk("move_at_frame", 32'(move_o), 32'h00);
        goto(833);
        chk("move_clean", 32'(move_o), 32'h24);
        goto(870);
        chk("move_hold", 32'(move_o), 32'h24);
        goto(897);
        chk("move_clear", 32'(move_o), 32'h00);

        // Both players fire together.
        shoot_i = 2'b11;
        exp_q.push_back('{cyc: 961, val: 2'b11});
        goto(917);
        shoot_i = 2'b00;
        goto(962);
        chk("dual_cool", 32'(cooldown_o), 32'h3);
        goto(1088);
        chk("dual_cool_last", 32'(cooldown_o), 32'h3);
        goto(1089);
        chk("dual_cool_end", 32'(cooldown_o), 32'h0);

        // Autofire on player 1: one shot every third frame while held.
        goto(1153);
        shoot_af_i = 2'b10;
        for (int k = 0; k < 4; k++) begin
            exp_af_q.push_back('{cyc: 1217 + 192 * k, val: 2'b10});
        end
        goto(1218);
        chk("af_cool", 32'(cooldown_af_o), 32'h2);
        goto(1345);
        chk("af_cool_end", 32'(cooldown_af_o), 32'h0);
        goto(1803);
        shoot_af_i = 2'b00;
        goto(2050);

        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        chk("exp_af_q_drained", 32'(exp_af_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
